// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-port data memory.
// Each accepted request takes ACCESS then RESP; a new grant may overlap RESP.
module mem_arbiter #(
  parameter int WIDTH = 64,
  parameter bit RR    = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_addr0,
  input  logic [WIDTH-1:0] req_addr1,
  input  logic [WIDTH-1:0] req_wdata0,
  input  logic [WIDTH-1:0] req_wdata1,
  input  logic [1:0]       req_word_we,
  input  logic [1:0]       req_byte_we,
  output logic [1:0]       resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_word_we,
  output logic             mem_byte_we,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             port_q;
  logic             word_q;
  logic             byte_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;

  logic             win_port;
  logic [1:0]       grant;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             sel_word;
  logic             sel_byte;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    win_port = 1'b0;
    if (req_valid == 2'b10)
      win_port = 1'b1;
    else if (req_valid == 2'b11 && RR)
      win_port = ~last_grant;

    grant = 2'b00;
    if ((state == IDLE || state == RESP) && !reset && (|req_valid))
      grant[win_port] = 1'b1;

    sel_addr  = win_port ? req_addr1  : req_addr0;
    sel_wdata = win_port ? req_wdata1 : req_wdata0;
    sel_word  = req_word_we[win_port];
    // Word store takes precedence over byte store when both are requested.
    sel_byte  = req_byte_we[win_port] & ~sel_word;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      port_q     <= 1'b0;
      word_q     <= 1'b0;
      byte_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (|grant) begin
            state      <= ACCESS;
            last_grant <= win_port;
            port_q     <= win_port;
            word_q     <= sel_word;
            byte_q     <= sel_byte;
            addr_q     <= sel_word ? {sel_addr[WIDTH-1:3], 3'b000} : sel_addr;
            wdata_q    <= sel_wdata;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          // Captured before the store commits, so a store returns the old word.
          rdata_q <= mem_rdata;
          state   <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates the strobes immediately so an in-flight access or response is dropped.
  assign req_ready   = grant;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_word_we = (state == ACCESS) && word_q && !reset;
  assign mem_byte_we = (state == ACCESS) && byte_q && !reset;
  assign resp_valid  = (state == RESP && !reset) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_rdata  = rdata_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one round-robin and one fixed-priority instance, each
// with its own memory, checked by vector table, directed sequences and a random run.
module tb_mem_arbiter;

  localparam int W = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Index 0 = round-robin instance, index 1 = fixed-priority instance.
  logic [1:0]   valid_i  [2];
  logic [W-1:0] addr0_i  [2];
  logic [W-1:0] addr1_i  [2];
  logic [W-1:0] wdata0_i [2];
  logic [W-1:0] wdata1_i [2];
  logic [1:0]   wwe_i    [2];
  logic [1:0]   bwe_i    [2];
  logic [1:0]   ready_o  [2];
  logic [1:0]   resp_o   [2];
  logic [W-1:0] rdata_o  [2];
  logic [W-1:0] maddr_o  [2];
  logic [W-1:0] mwdata_o [2];
  logic [W-1:0] mrdata_i [2];
  logic         mwwe_o   [2];
  logic         mbwe_o   [2];
  logic         busy_o   [2];

  mem_arbiter #(.WIDTH(W), .RR(1'b1)) dut_rr (
    .clock(clock), .reset(reset),
    .req_valid(valid_i[0]), .req_ready(ready_o[0]),
    .req_addr0(addr0_i[0]), .req_addr1(addr1_i[0]),
    .req_wdata0(wdata0_i[0]), .req_wdata1(wdata1_i[0]),
    .req_word_we(wwe_i[0]), .req_byte_we(bwe_i[0]),
    .resp_valid(resp_o[0]), .resp_rdata(rdata_o[0]),
    .mem_addr(maddr_o[0]), .mem_wdata(mwdata_o[0]),
    .mem_word_we(mwwe_o[0]), .mem_byte_we(mbwe_o[0]),
    .mem_rdata(mrdata_i[0]), .busy(busy_o[0])
  );

  mem_arbiter #(.WIDTH(W), .RR(1'b0)) dut_fp (
    .clock(clock), .reset(reset),
    .req_valid(valid_i[1]), .req_ready(ready_o[1]),
    .req_addr0(addr0_i[1]), .req_addr1(addr1_i[1]),
    .req_wdata0(wdata0_i[1]), .req_wdata1(wdata1_i[1]),
    .req_word_we(wwe_i[1]), .req_byte_we(bwe_i[1]),
    .resp_valid(resp_o[1]), .resp_rdata(rdata_o[1]),
    .mem_addr(maddr_o[1]), .mem_wdata(mwdata_o[1]),
    .mem_word_we(mwwe_o[1]), .mem_byte_we(mbwe_o[1]),
    .mem_rdata(mrdata_i[1]), .busy(busy_o[1])
  );

  // Memory: 32 words indexed by address bits [7:3]; a byte store writes lane addr[2:0].
  logic [W-1:0] env_mem [2][32];
  logic         init_en = 1'b0;
  logic [4:0]   init_idx = '0;
  logic [W-1:0] init_data = '0;

  function automatic logic [W-1:0] byte_merge(input logic [W-1:0] w, input logic [2:0] lane,
                                              input logic [7:0] b);
    logic [W-1:0] r;
    r = w;
    r[8*lane +: 8] = b;
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) mrdata_i[i] = env_mem[i][maddr_o[i][7:3]];
  end

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (init_en)
        env_mem[i][init_idx] <= init_data;
      else if (mwwe_o[i])
        env_mem[i][maddr_o[i][7:3]] <= mwdata_o[i];
      else if (mbwe_o[i])
        env_mem[i][maddr_o[i][7:3]] <= byte_merge(env_mem[i][maddr_o[i][7:3]], maddr_o[i][2:0],
                                                  mwdata_o[i][7:0]);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      valid_i[i] = 2'b00;
      wwe_i[i]   = 2'b00;
      bwe_i[i]   = 2'b00;
    end
  endtask

  task automatic set_req(input int port, input logic [W-1:0] a, input logic [W-1:0] d,
                         input logic ww, input logic bw);
    for (int i = 0; i < 2; i++) begin
      valid_i[i][port] = 1'b1;
      wwe_i[i][port]   = ww;
      bwe_i[i][port]   = bw;
      if (port == 0) begin
        addr0_i[i] = a; wdata0_i[i] = d;
      end else begin
        addr1_i[i] = a; wdata1_i[i] = d;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  // Loads one word into both memories; reset is held so neither DUT writes meanwhile.
  task automatic load_word(input int idx, input logic [W-1:0] data);
    reset     = 1'b1;
    init_en   = 1'b1;
    init_idx  = idx[4:0];
    init_data = data;
    tick();
    init_en   = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    int         pre;    // 0: none, 1: grant port 0 first, 2: grant port 1 first
    logic [1:0] valid;
    logic [1:0] exp_rr;
    logic [1:0] exp_fp;
  } vec_t;

  vec_t vecs [9];

  // Reference model state for the random run.
  logic [W-1:0] ref_mem [2][32];
  bit           pv [2][2];
  logic [W-1:0] pa [2][2];
  logic [W-1:0] pd [2][2];
  bit           pw [2][2];
  bit           pb [2][2];
  bit           acc_v [2];
  int           acc_port [2];
  logic [W-1:0] acc_addr [2];
  logic [W-1:0] acc_wdata [2];
  bit           acc_w [2];
  bit           acc_b [2];
  logic [W-1:0] acc_data [2];
  bit           rsp_v [2];
  int           rsp_port [2];
  logic [W-1:0] rsp_data [2];
  logic [W-1:0] last_data [2];
  int           last_win [2];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   exp_r;
    logic [1:0]   exp_p;
    logic [W-1:0] a_word, b_word;

    vecs[0] = '{1'b1, 0, 2'b11, 2'b00, 2'b00};
    vecs[1] = '{1'b0, 0, 2'b00, 2'b00, 2'b00};
    vecs[2] = '{1'b0, 0, 2'b01, 2'b01, 2'b01};
    vecs[3] = '{1'b0, 0, 2'b10, 2'b10, 2'b10};
    vecs[4] = '{1'b0, 0, 2'b11, 2'b01, 2'b01};
    vecs[5] = '{1'b0, 1, 2'b11, 2'b10, 2'b01};
    vecs[6] = '{1'b0, 2, 2'b11, 2'b01, 2'b01};
    vecs[7] = '{1'b0, 1, 2'b10, 2'b10, 2'b10};
    vecs[8] = '{1'b0, 2, 2'b01, 2'b01, 2'b01};

    for (int i = 0; i < 2; i++) begin
      addr0_i[i] = '0; addr1_i[i] = '0; wdata0_i[i] = '0; wdata1_i[i] = '0;
    end
    idle_inputs();
    tick();
    do_reset();

    // Reset state.
    sample();
    check("reset busy rr", W'(busy_o[0]), '0);
    check("reset rdata rr", rdata_o[0], '0);
    check("reset maddr rr", maddr_o[0], '0);

    // Arbitration from IDLE, optionally after a priming grant that moves the pointer.
    for (int k = 0; k < 9; k++) begin
      do_reset();
      if (vecs[k].pre != 0) begin
        set_req(vecs[k].pre - 1, 64'h40, '0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();
      end
      reset = vecs[k].rst;
      for (int i = 0; i < 2; i++) valid_i[i] = vecs[k].valid;
      sample();
      check($sformatf("vec%0d ready rr", k), W'(ready_o[0]), W'(vecs[k].exp_rr));
      check($sformatf("vec%0d ready fp", k), W'(ready_o[1]), W'(vecs[k].exp_fp));
      check($sformatf("vec%0d busy rr", k), W'(busy_o[0]), '0);
      tick();
      reset = 1'b0;
      idle_inputs();
    end

    // Single load: accept at t, response at t+2, data held afterwards.
    load_word(2, 64'hDEADBEEF_00000001);
    do_reset();
    set_req(0, 64'h10, '0, 1'b0, 1'b0);
    sample();
    check("load ready rr", W'(ready_o[0]), W'(2'b01));
    check("load ready fp", W'(ready_o[1]), W'(2'b01));
    tick();
    idle_inputs();
    sample();
    check("load t+1 resp", W'(resp_o[0]), '0);
    check("load t+1 ready", W'(ready_o[0]), '0);
    check("load t+1 maddr", maddr_o[0], 64'h10);
    check("load t+1 we", W'({mwwe_o[0], mbwe_o[0]}), '0);
    check("load t+1 busy", W'(busy_o[0]), W'(1'b1));
    tick();
    sample();
    check("load t+2 resp", W'(resp_o[0]), W'(2'b01));
    check("load t+2 rdata", rdata_o[0], 64'hDEADBEEF_00000001);
    tick();
    sample();
    check("load t+3 resp", W'(resp_o[0]), '0);
    check("load t+3 rdata hold", rdata_o[0], 64'hDEADBEEF_00000001);
    check("load t+3 busy", W'(busy_o[0]), '0);

    // Continuous contention: RR alternates 0,1,0,1; fixed priority always port 0.
    a_word = 64'hAAAA_0000_1111_0000;
    b_word = 64'hBBBB_0000_2222_0000;
    load_word(2, a_word);
    load_word(3, b_word);
    do_reset();
    set_req(0, 64'h10, '0, 1'b0, 1'b0);
    set_req(1, 64'h18, '0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      sample();
      exp_r = 2'b00;
      exp_p = 2'b00;
      if (k % 2 == 0) exp_r = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
      if (k >= 2 && k % 2 == 0) exp_p = (((k - 2) / 2) % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("rr cyc%0d ready", k), W'(ready_o[0]), W'(exp_r));
      check($sformatf("rr cyc%0d resp", k), W'(resp_o[0]), W'(exp_p));
      if (exp_p != 2'b00)
        check($sformatf("rr cyc%0d rdata", k), rdata_o[0], (exp_p == 2'b01) ? a_word : b_word);
      check($sformatf("fp cyc%0d ready", k), W'(ready_o[1]), (k % 2 == 0) ? W'(2'b01) : '0);
      check($sformatf("fp cyc%0d resp", k), W'(resp_o[1]), (k >= 2 && k % 2 == 0) ? W'(2'b01) : '0);
      tick();
    end
    for (int i = 0; i < 2; i++) valid_i[i][0] = 1'b0;
    sample();
    check("rr single p1 ready", W'(ready_o[0]), W'(2'b10));
    check("rr cyc8 resp", W'(resp_o[0]), W'(2'b10));
    check("fp p1 after drop ready", W'(ready_o[1]), W'(2'b10));
    check("fp cyc8 resp", W'(resp_o[1]), W'(2'b01));
    tick();
    idle_inputs();

    // Store precedence and alignment, then read-back of the stored word.
    load_word(5, 64'hA5A5A5A5_5A5A5A5A);
    do_reset();
    set_req(1, 64'h2B, 64'h1122334455667788, 1'b1, 1'b1);
    sample();
    check("store ready", W'(ready_o[0]), W'(2'b10));
    tick();
    idle_inputs();
    sample();
    check("store word_we", W'(mwwe_o[0]), W'(1'b1));
    check("store byte_we", W'(mbwe_o[0]), '0);
    check("store maddr", maddr_o[0], 64'h28);
    check("store wdata", mwdata_o[0], 64'h1122334455667788);
    tick();
    set_req(0, 64'h28, '0, 1'b0, 1'b0);
    sample();
    check("store resp", W'(resp_o[0]), W'(2'b10));
    check("store old rdata", rdata_o[0], 64'hA5A5A5A5_5A5A5A5A);
    check("overlap ready", W'(ready_o[0]), W'(2'b01));
    check("store wr enable off", W'({mwwe_o[0], mbwe_o[0]}), '0);
    tick();
    idle_inputs();
    sample();
    check("readback maddr", maddr_o[0], 64'h28);
    tick();
    sample();
    check("readback resp", W'(resp_o[0]), W'(2'b01));
    check("readback rdata", rdata_o[0], 64'h1122334455667788);
    tick();

    // Reset during ACCESS of a store: no write, no response.
    load_word(6, 64'h0BAD_F00D_0000_0006);
    do_reset();
    set_req(0, 64'h30, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    sample();
    check("abort ready", W'(ready_o[0]), W'(2'b01));
    tick();
    idle_inputs();
    reset = 1'b1;
    sample();
    check("abort word_we", W'(mwwe_o[0]), '0);
    check("abort resp", W'(resp_o[0]), '0);
    tick();
    reset = 1'b0;
    sample();
    check("abort busy", W'(busy_o[0]), '0);
    check("abort resp after", W'(resp_o[0]), '0);
    tick();
    sample();
    check("abort resp later", W'(resp_o[0]), '0);
    check("abort mem intact", env_mem[0][6], 64'h0BAD_F00D_0000_0006);

    // Reset during RESP: the pending response is suppressed.
    do_reset();
    set_req(0, 64'h30, '0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    tick();
    reset = 1'b1;
    sample();
    check("resp suppressed", W'(resp_o[0]), '0);
    tick();
    reset = 1'b0;
    sample();
    check("resp suppressed after", W'(resp_o[0]), '0);
    check("resp suppressed busy", W'(busy_o[0]), '0);

    // Idle for 10 cycles.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      sample();
      for (int i = 0; i < 2; i++)
        check($sformatf("idle cyc%0d inst%0d", k, i),
              W'({busy_o[i], ready_o[i], mwwe_o[i], mbwe_o[i], resp_o[i]}), '0);
      tick();
    end

    // Randomized run against a transaction-level model, independent stimulus per instance.
    for (int idx = 0; idx < 32; idx++) begin
      logic [W-1:0] v;
      v = {$urandom(), $urandom()};
      load_word(idx, v);
      for (int i = 0; i < 2; i++) ref_mem[i][idx] = v;
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      acc_v[i] = 1'b0; rsp_v[i] = 1'b0; last_data[i] = '0; last_win[i] = 1;
      for (int p = 0; p < 2; p++) pv[i][p] = 1'b0;
    end

    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (!pv[i][p] && $urandom_range(0, 1) == 1) begin
            pv[i][p] = 1'b1;
            pa[i][p] = {$urandom(), $urandom()};
            pd[i][p] = {$urandom(), $urandom()};
            pw[i][p] = ($urandom_range(0, 2) == 0);
            pb[i][p] = ($urandom_range(0, 2) == 0);
          end
        end
        valid_i[i]  = {pv[i][1], pv[i][0]};
        wwe_i[i]    = {pw[i][1], pw[i][0]};
        bwe_i[i]    = {pb[i][1], pb[i][0]};
        addr0_i[i]  = pa[i][0];
        addr1_i[i]  = pa[i][1];
        wdata0_i[i] = pd[i][0];
        wdata1_i[i] = pd[i][1];
      end
      sample();
      for (int i = 0; i < 2; i++) begin
        int win;
        logic [4:0] idx;
        exp_p = 2'b00;
        if (rsp_v[i]) begin
          exp_p[rsp_port[i]] = 1'b1;
          last_data[i] = rsp_data[i];
        end
        check($sformatf("rnd%0d inst%0d resp", cyc, i), W'(resp_o[i]), W'(exp_p));
        check($sformatf("rnd%0d inst%0d rdata", cyc, i), rdata_o[i], last_data[i]);
        check($sformatf("rnd%0d inst%0d we", cyc, i), W'({mwwe_o[i], mbwe_o[i]}),
              acc_v[i] ? W'({acc_w[i], acc_b[i]}) : '0);
        if (acc_v[i]) begin
          check($sformatf("rnd%0d inst%0d maddr", cyc, i), maddr_o[i], acc_addr[i]);
          check($sformatf("rnd%0d inst%0d mwdata", cyc, i), mwdata_o[i], acc_wdata[i]);
        end
        win = -1;
        if (!acc_v[i]) begin
          if (pv[i][0] && pv[i][1]) win = (i == 0) ? 1 - last_win[i] : 0;
          else if (pv[i][0]) win = 0;
          else if (pv[i][1]) win = 1;
        end
        exp_r = 2'b00;
        if (win >= 0) exp_r[win] = 1'b1;
        check($sformatf("rnd%0d inst%0d ready", cyc, i), W'(ready_o[i]), W'(exp_r));

        rsp_v[i]    = acc_v[i];
        rsp_port[i] = acc_port[i];
        rsp_data[i] = acc_data[i];
        acc_v[i]    = (win >= 0);
        if (win >= 0) begin
          idx          = pa[i][win][7:3];
          acc_port[i]  = win;
          acc_w[i]     = pw[i][win];
          acc_b[i]     = pb[i][win] && !pw[i][win];
          acc_addr[i]  = pw[i][win] ? {pa[i][win][W-1:3], 3'b000} : pa[i][win];
          acc_wdata[i] = pd[i][win];
          acc_data[i]  = ref_mem[i][idx];
          if (acc_w[i])
            ref_mem[i][idx] = pd[i][win];
          else if (acc_b[i])
            ref_mem[i][idx] = byte_merge(ref_mem[i][idx], pa[i][win][2:0], pd[i][win][7:0]);
          last_win[i] = win;
          pv[i][win]  = 1'b0;
        end
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
    for (int i = 0; i < 2; i++)
      for (int idx = 0; idx < 32; idx++)
        check($sformatf("rnd final mem inst%0d word%0d", i, idx), env_mem[i][idx], ref_mem[i][idx]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WIDTH, 64, data and address width in bits.
REQ-002 Parameter: RR, 1, arbitration mode (1 = round-robin, 0 = fixed priority to port 0).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-port request valid (bit 0 = CPU, bit 1 = DMA).
REQ-006 req_ready  output  2  per-port request accept, combinational.
REQ-007 req_addr0, req_addr1  input  WIDTH  per-port byte address.
REQ-008 req_wdata0, req_wdata1  input  WIDTH  per-port store data.
REQ-009 req_word_we, req_byte_we  input  2  per-port word/byte store enables; both low = load.
REQ-010 resp_valid  output  2  per-port one-cycle response pulse.
REQ-011 resp_rdata  output  WIDTH  read data for the port flagged in resp_valid.
REQ-012 mem_addr  output  WIDTH  address to single-port data memory.
REQ-013 mem_wdata  output  WIDTH  store data to memory.
REQ-014 mem_word_we, mem_byte_we  output  1  memory write enables; the write commits on the rising edge ending the ACCESS cycle.
REQ-015 mem_rdata  input  WIDTH  memory read data, combinational from mem_addr.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS, and RESP.
REQ-018 In IDLE or RESP with any req_valid high, the arbiter SHALL assert exactly one req_ready bit (the winner), latch the winner's addr/wdata/enables/port id, and go to ACCESS.
REQ-019 In IDLE or RESP with no req_valid, req_ready SHALL be 0 and the next state SHALL be IDLE.
REQ-020 In ACCESS, req_ready SHALL be 0, the memory SHALL be driven from the latched request, mem_rdata SHALL be captured, and the next state SHALL be RESP.
REQ-021 In RESP, resp_valid[latched port] SHALL be 1 for exactly one cycle and resp_rdata SHALL equal the captured data; a new grant in the same cycle is permitted.
REQ-022 Latency SHALL be: accept at cycle t, memory access at t+1, resp_valid at t+2; sustained throughput SHALL be one access per 2 cycles.
REQ-023 Round-robin (RR=1): a last-grant pointer SHALL update on every grant; when both ports are valid, the port not granted last SHALL win; when a single port is valid, that port SHALL win regardless of the pointer.
REQ-024 Fixed priority (RR=0): port 0 SHALL win whenever valid.
REQ-025 Store ops: if word_we and byte_we are both set, word_we SHALL win (mem_byte_we=0); a word op SHALL drive mem_addr = {addr[WIDTH-1:3],3'b000}; a byte op or load SHALL drive the unmodified addr.
REQ-026 Outside ACCESS, mem_word_we and mem_byte_we SHALL be 0; mem_addr and mem_wdata SHALL hold the last latched values.
REQ-027 Requesters hold valid and payload stable until ready; the arbiter SHALL sample the payload only in the cycle ready is high.
REQ-028 A load response SHALL carry mem_rdata; a store response SHALL also pulse resp_valid, with resp_rdata equal to mem_rdata sampled before the write.
REQ-029 resp_valid SHALL never have both bits set.
REQ-030 resp_rdata SHALL hold its value when resp_valid is 0.

Reset
REQ-031 When reset is high, the next state SHALL be IDLE; the pointer SHALL be set so port 0 wins first; latched registers and resp_rdata SHALL be cleared to 0.
REQ-032 While reset is high, req_ready, resp_valid, mem_word_we, and mem_byte_we SHALL be forced to 0, even in ACCESS.
REQ-033 Reset asserted in ACCESS SHALL abort the access (no memory write, no response).
REQ-034 Reset asserted in RESP SHALL suppress the pending response.

Verification
REQ-035 Single load: port0 load addr 0x10, memory holds 0xDEADBEEF_00000001 -> ready0 at t, resp_valid=2'b01 at t+2, rdata=0xDEADBEEF_00000001.
REQ-036 Contention, RR=1: both ports valid continuously from reset -> grants 0,1,0,1 on cycles t, t+2, t+4, t+6; responses 2 cycles after each grant.
REQ-037 Contention, RR=0: both ports valid for 3 grants -> all three go to port 0; port 1 is granted only after valid0 drops.
REQ-038 Store precedence: port1 word_we=byte_we=1, addr 0x2B, wdata 0x1122334455667788 -> mem_word_we=1, mem_byte_we=0, mem_addr=0x28 in ACCESS; a following load of 0x28 returns 0x1122334455667788.
REQ-039 Reset mid-access: reset high during ACCESS of a port0 store -> no write enable seen, no resp_valid, state IDLE, memory unchanged.
REQ-040 Idle: no valid for 10 cycles -> busy=0, req_ready=0, write enables 0 throughout.
